// File: rtl/seven_seg_pkg.sv
// Shared constants, slot enumeration and anode decode for the seven-segment
// scan stage. All patterns are active-low.
package seven_seg_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] SEG_ZERO   = 8'hC0;
  localparam logic [3:0] AN_ALL_OFF = 4'hF;

  typedef enum logic [1:0] {
    SLOT_UNITS = 2'd0,
    SLOT_TENS  = 2'd1,
    SLOT_HUNDS = 2'd2,
    SLOT_SPARE = 2'd3
  } slot_e;

  // One active-low anode per real digit; the spare slot keeps every anode off.
  function automatic logic [3:0] anode_for(slot_e idx);
    return (idx == SLOT_SPARE) ? AN_ALL_OFF : ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Connection bundle between the score keeper (master) and the display scan
// stage (slave): three segment patterns plus Done in, anodes/segments out.
interface seven_seg_scan_if;

  logic [7:0] seven_data_hunds;
  logic [7:0] seven_data_tens;
  logic [7:0] seven_data_units;
  logic       Done;
  logic [3:0] an;
  logic [7:0] seg;
  logic       frame_sync;

  modport master (
    output seven_data_hunds, seven_data_tens, seven_data_units, Done,
    input  an, seg, frame_sync
  );

  modport slave (
    input  seven_data_hunds, seven_data_tens, seven_data_units, Done,
    output an, seg, frame_sync
  );

endinterface

// File: rtl/seven_seg_slot_timer.sv
// Digit-slot timebase: counts clk cycles per slot, steps the slot index,
// flags the anti-ghosting blank window and pulses frame_sync once per frame.
module seven_seg_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic  clk,
  input  logic  rst_n,
  output slot_e slot_idx,
  output logic  in_blank,
  output logic  frame_sync
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] slot_cnt;
  logic             slot_wrap;

  // Compare at full 32-bit width so the limits are never truncated to CNT_W.
  assign slot_wrap = (32'(slot_cnt) == REFRESH_DIV - 1);
  assign in_blank  = (32'(slot_cnt) < BLANK_CYCLES);

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      slot_idx   <= SLOT_UNITS;
      frame_sync <= 1'b0;
    end else begin
      frame_sync <= slot_wrap && (slot_idx == SLOT_SPARE);
      if (slot_wrap) begin
        slot_cnt <= '0;
        slot_idx <= slot_e'(slot_idx + 2'd1);
      end else begin
        slot_cnt <= slot_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// 4-digit common-anode scan driver: shadows the score on Done, multiplexes
// the digits with a blank interval per slot. Optional leading-zero blanking
// is enabled by defining SEVEN_SEG_LZB_EN.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input logic             clk,
  input logic             rst_n,
  seven_seg_scan_if.slave bus
);

`ifdef SEVEN_SEG_LZB_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  slot_e      slot_idx;
  logic       in_blank;
  logic [7:0] shadow_h;
  logic [7:0] shadow_t;
  logic [7:0] shadow_u;
  logic [7:0] digit_seg;
  logic [3:0] an_next;
  logic [7:0] seg_next;

  seven_seg_slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_idx   (slot_idx),
    .in_blank   (in_blank),
    .frame_sync (bus.frame_sync)
  );

  // All three digits load together so the display never mixes two scores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_h <= SEG_BLANK;
      shadow_t <= SEG_BLANK;
      shadow_u <= SEG_BLANK;
    end else if (bus.Done) begin
      shadow_h <= bus.seven_data_hunds;
      shadow_t <= bus.seven_data_tens;
      shadow_u <= bus.seven_data_units;
    end
  end

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    digit_seg = SEG_BLANK;
    an_next   = AN_ALL_OFF;
    seg_next  = SEG_BLANK;

    case (slot_idx)
      SLOT_UNITS: digit_seg = shadow_u;
      SLOT_TENS: begin
        if (LZB_EN && shadow_h == SEG_ZERO && shadow_t == SEG_ZERO)
          digit_seg = SEG_BLANK;
        else
          digit_seg = shadow_t;
      end
      SLOT_HUNDS: begin
        if (LZB_EN && shadow_h == SEG_ZERO)
          digit_seg = SEG_BLANK;
        else
          digit_seg = shadow_h;
      end
      default: digit_seg = SEG_BLANK;
    endcase

    // Spare slot stays dark so each real digit keeps a 1/4 duty cycle.
    if (!in_blank && slot_idx != SLOT_SPARE) begin
      an_next  = anode_for(slot_idx);
      seg_next = digit_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an  <= AN_ALL_OFF;
      bus.seg <= SEG_BLANK;
    end else begin
      bus.an  <= an_next;
      bus.seg <= seg_next;
    end
  end

endmodule
